// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_e        FSM encodings S_BOOT/S_RUN/S_STALL/S_FLUSH
//   NOP_WORD       default bubble instruction (sll $0,$0,0)
//   DEF_RESET_PC   default reset byte address
//   DEF_MEM_WORDS  default instruction memory depth in words
//   align_target   clears the byte-offset bits of a redirect target
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_FLUSH = 2'd3
   } state_e;

   localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam int unsigned DEF_MEM_WORDS = 1024;

   function automatic logic [31:0] align_target(input logic [31:0] target);
      return target & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port of the fetch stage.
//   inst_reg  word index presented to inst_mem (fetch side drives)
//   inst_in   word returned combinationally by inst_mem
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_unit_if;

   logic [31:0] inst_reg;
   logic [31:0] inst_in;

   modport master (output inst_reg, input inst_in);
   modport slave  (input inst_reg, output inst_in);

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux with redirect alignment check.
//   pc             current PC (byte address)
//   hold           keep PC (stall, or boot cycle)
//   branch_taken   / branch_target   EX branch redirect
//   jump           / jump_target     ID jump redirect (highest priority)
//   next_pc        selected next PC
//   pc_plus4       pc + 4, modulo 2^32
//   redirect       a jump or taken branch is active
//   misaligned     the selected redirect target had nonzero [1:0]
module fetch_unit_next_pc_sel
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        hold,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        redirect,
   output logic        misaligned
);

   always_comb begin
      pc_plus4   = pc + 32'd4;
      redirect   = jump | branch_taken;
      misaligned = 1'b0;
      next_pc    = pc_plus4;
      if (jump) begin
         next_pc    = align_target(jump_target);
         misaligned = |jump_target[1:0];
      end else if (branch_taken) begin
         next_pc    = align_target(branch_target);
         misaligned = |branch_target[1:0];
      end else if (hold) begin
         next_pc = pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, IF/ID pipeline register,
// fetch/bubble counters and sticky misalignment flag.
//   clk, rst                         clock, synchronous active-high reset
//   stall                            hold PC and IF/ID
//   branch_taken/branch_target       EX branch redirect
//   jump/jump_target                 ID jump redirect
//   imem                             inst_mem port (inst_reg out, inst_in back)
//   pc_out                           current PC
//   if_id_inst/if_id_pc4/if_id_valid IF/ID register
//   misalign_err                     sticky redirect misalignment
//   fetch_count/bubble_count         wrapping event counters
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
   parameter logic [31:0] NOP       = NOP_WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   input  logic               jump,
   input  logic [31:0]        jump_target,
   fetch_unit_if.master       imem,
   output logic [31:0]        pc_out,
   output logic [31:0]        if_id_inst,
   output logic [31:0]        if_id_pc4,
   output logic               if_id_valid,
   output logic               misalign_err,
   output logic [31:0]        fetch_count,
   output logic [31:0]        bubble_count
);

   logic [31:0] pc;
   state_e      state;
   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        misaligned;
   logic        in_range;

   assign imem.inst_reg = {2'b00, pc[31:2]};
   assign pc_out        = pc;
   assign in_range      = imem.inst_reg < 32'(MEM_WORDS);

   // The boot cycle holds PC so the RESET_PC word is fetched on the cycle after it.
   fetch_unit_next_pc_sel u_next_pc_sel (
      .pc            (pc),
      .hold          (stall | (state == S_BOOT)),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .next_pc       (next_pc),
      .pc_plus4      (pc_plus4),
      .redirect      (redirect),
      .misaligned    (misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         state        <= S_BOOT;
         if_id_inst   <= NOP;
         if_id_pc4    <= 32'h0;
         if_id_valid  <= 1'b0;
         misalign_err <= 1'b0;
         fetch_count  <= 32'h0;
         bubble_count <= 32'h0;
      end else begin
         pc <= next_pc;
         if (misaligned) begin
            misalign_err <= 1'b1;
         end
         if (redirect) begin
            // Redirect wins over stall: the wrong-path fetch is squashed.
            if_id_inst   <= NOP;
            if_id_pc4    <= 32'h0;
            if_id_valid  <= 1'b0;
            bubble_count <= bubble_count + 32'd1;
            state        <= S_FLUSH;
         end else if (stall) begin
            bubble_count <= bubble_count + 32'd1;
            state        <= S_STALL;
         end else begin
            state <= S_RUN;
            if ((state == S_BOOT) || !in_range) begin
               if_id_inst   <= NOP;
               if_id_pc4    <= 32'h0;
               if_id_valid  <= 1'b0;
               bubble_count <= bubble_count + 32'd1;
            end else begin
               if_id_inst  <= imem.inst_in;
               if_id_pc4   <= pc_plus4;
               if_id_valid <= 1'b1;
               fetch_count <= fetch_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected values, a negedge
// monitor pops and compares. Instance 0 uses RESET_PC=0, instance 1 RESET_PC=FFFF_FFFC.
module tb_fetch_unit;

   localparam int SIG_PC    = 0;
   localparam int SIG_IREG  = 1;
   localparam int SIG_INST  = 2;
   localparam int SIG_PC4   = 3;
   localparam int SIG_VALID = 4;
   localparam int SIG_MIS   = 5;
   localparam int SIG_FC    = 6;
   localparam int SIG_BC    = 7;

   logic        clk = 1'b0;
   logic        rst0 = 1'b1;
   logic        rst1 = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;

   logic [31:0] pc0, ifi0, ifp0, fc0, bc0;
   logic        ifv0, mis0;
   logic [31:0] pc1, ifi1, ifp1, fc1, bc1;
   logic        ifv1, mis1;

   logic [31:0] mem [0:1023];

   int total = 0;
   int bad   = 0;

   int          q_dut [$];
   int          q_sig [$];
   logic [31:0] q_exp [$];
   string       q_name [$];

   fetch_unit_if imem0 ();
   fetch_unit_if imem1 ();

   assign imem0.inst_in = (imem0.inst_reg < 32'd1024) ? mem[imem0.inst_reg[9:0]] : 32'h0;
   assign imem1.inst_in = (imem1.inst_reg < 32'd1024) ? mem[imem1.inst_reg[9:0]] : 32'h0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(1024), .NOP(32'h0000_0000)) dut0 (
      .clk           (clk),
      .rst           (rst0),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem          (imem0),
      .pc_out        (pc0),
      .if_id_inst    (ifi0),
      .if_id_pc4     (ifp0),
      .if_id_valid   (ifv0),
      .misalign_err  (mis0),
      .fetch_count   (fc0),
      .bubble_count  (bc0)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MEM_WORDS(1024), .NOP(32'h0000_0000)) dut1 (
      .clk           (clk),
      .rst           (rst1),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem          (imem1),
      .pc_out        (pc1),
      .if_id_inst    (ifi1),
      .if_id_pc4     (ifp1),
      .if_id_valid   (ifv1),
      .misalign_err  (mis1),
      .fetch_count   (fc1),
      .bubble_count  (bc1)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int dut, input int sig);
      logic [31:0] v;
      v = 32'hDEAD_BEEF;
      if (dut == 0) begin
         case (sig)
            SIG_PC:    v = pc0;
            SIG_IREG:  v = imem0.inst_reg;
            SIG_INST:  v = ifi0;
            SIG_PC4:   v = ifp0;
            SIG_VALID: v = {31'h0, ifv0};
            SIG_MIS:   v = {31'h0, mis0};
            SIG_FC:    v = fc0;
            default:   v = bc0;
         endcase
      end else begin
         case (sig)
            SIG_PC:    v = pc1;
            SIG_IREG:  v = imem1.inst_reg;
            SIG_INST:  v = ifi1;
            SIG_PC4:   v = ifp1;
            SIG_VALID: v = {31'h0, ifv1};
            SIG_MIS:   v = {31'h0, mis1};
            SIG_FC:    v = fc1;
            default:   v = bc1;
         endcase
      end
      return v;
   endfunction

   // Monitor: every negedge, drain whatever the stimulus queued since the last edge.
   always @(negedge clk) begin : monitor
      int          d;
      int          s;
      logic [31:0] e;
      logic [31:0] a;
      string       n;
      while (q_sig.size() != 0) begin
         d = q_dut.pop_front();
         s = q_sig.pop_front();
         e = q_exp.pop_front();
         n = q_name.pop_front();
         a = actual(d, s);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s (dut%0d sig%0d): got %h want %h", n, d, s, a, e);
         end
      end
   end

   task automatic chk(input int dut, input int sig, input logic [31:0] v, input string name);
      q_dut.push_back(dut);
      q_sig.push_back(sig);
      q_exp.push_back(v);
      q_name.push_back(name);
   endtask

   task automatic chk_ifid(input int dut, input logic [31:0] inst, input logic [31:0] pc4,
                           input logic valid, input string name);
      chk(dut, SIG_INST, inst, {name, ".inst"});
      chk(dut, SIG_PC4, pc4, {name, ".pc4"});
      chk(dut, SIG_VALID, {31'h0, valid}, {name, ".valid"});
   endtask

   task automatic chk_reset(input int dut, input logic [31:0] rpc, input string name);
      chk(dut, SIG_PC, rpc, {name, ".pc"});
      chk_ifid(dut, 32'h0, 32'h0, 1'b0, name);
      chk(dut, SIG_MIS, 32'h0, {name, ".mis"});
      chk(dut, SIG_FC, 32'h0, {name, ".fc"});
      chk(dut, SIG_BC, 32'h0, {name, ".bc"});
   endtask

   // Apply inputs for one cycle, then return #1 after the clock edge.
   task automatic step(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
      stall         = s;
      branch_taken  = b;
      branch_target = bt;
      jump          = j;
      jump_target   = jt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + 32'(i);

      // Reset, two cycles.
      idle();
      idle();
      chk_reset(0, 32'h0, "rst0");

      // Boot bubble, then A, B.
      rst0 = 1'b0;
      idle();
      chk_ifid(0, 32'h0, 32'h0, 1'b0, "boot");
      chk(0, SIG_PC, 32'h0, "boot.pc");
      chk(0, SIG_BC, 32'd1, "boot.bc");
      idle();
      chk_ifid(0, 32'hC000_0000, 32'd4, 1'b1, "A");
      chk(0, SIG_IREG, 32'd1, "A.ireg");
      idle();
      chk_ifid(0, 32'hC000_0001, 32'd8, 1'b1, "B");
      chk(0, SIG_IREG, 32'd2, "B.ireg");

      // Stall three cycles at pc=8.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         chk(0, SIG_PC, 32'd8, "stall.pc");
         chk_ifid(0, 32'hC000_0001, 32'd8, 1'b1, "stall");
         chk(0, SIG_BC, 32'd2 + 32'(k), "stall.bc");
      end
      idle();
      chk_ifid(0, 32'hC000_0002, 32'd12, 1'b1, "C");
      chk(0, SIG_IREG, 32'd3, "C.ireg");
      chk(0, SIG_FC, 32'd3, "C.fc");

      // Taken branch to 0x40.
      step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      chk_ifid(0, 32'h0, 32'h0, 1'b0, "br");
      chk(0, SIG_PC, 32'h40, "br.pc");
      chk(0, SIG_IREG, 32'h10, "br.ireg");
      idle();
      chk_ifid(0, 32'hC000_0010, 32'h44, 1'b1, "br.tgt");

      // Stall with jump: redirect wins.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
      chk(0, SIG_PC, 32'h20, "stj.pc");
      chk_ifid(0, 32'h0, 32'h0, 1'b0, "stj");
      chk(0, SIG_BC, 32'd6, "stj.bc");
      idle();
      chk_ifid(0, 32'hC000_0008, 32'h24, 1'b1, "stj.tgt");

      // Jump and branch together: jump target taken.
      step(1'b0, 1'b1, 32'h100, 1'b1, 32'h80);
      chk(0, SIG_PC, 32'h80, "jb.pc");
      chk_ifid(0, 32'h0, 32'h0, 1'b0, "jb");
      idle();
      chk_ifid(0, 32'hC000_0020, 32'h84, 1'b1, "jb.tgt");
      chk(0, SIG_FC, 32'd6, "jb.fc");
      chk(0, SIG_MIS, 32'h0, "jb.mis");

      // Branch to first out-of-range word: fetch there is a bubble.
      step(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0);
      chk(0, SIG_PC, 32'h1000, "oor.pc");
      idle();
      chk_ifid(0, 32'h0, 32'h0, 1'b0, "oor");
      chk(0, SIG_PC, 32'h1004, "oor.pc2");
      chk(0, SIG_BC, 32'd9, "oor.bc");
      chk(0, SIG_FC, 32'd6, "oor.fc");

      // Misaligned jump target.
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
      chk(0, SIG_PC, 32'h20, "mis.pc");
      chk(0, SIG_MIS, 32'h1, "mis.set");
      idle();
      chk_ifid(0, 32'hC000_0008, 32'h24, 1'b1, "mis.tgt");
      chk(0, SIG_MIS, 32'h1, "mis.sticky");
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk(0, SIG_MIS, 32'h1, "mis.sticky2");
      chk(0, SIG_BC, 32'd11, "mis.bc");
      rst0 = 1'b1;
      idle();
      chk_reset(0, 32'h0, "rst0b");

      // Instance 1: RESET_PC at the top of the address space.
      chk_reset(1, 32'hFFFF_FFFC, "rst1");
      chk(1, SIG_IREG, 32'h3FFF_FFFF, "rst1.ireg");
      rst1 = 1'b0;
      idle();
      chk_ifid(1, 32'h0, 32'h0, 1'b0, "boot1");
      chk(1, SIG_PC, 32'hFFFF_FFFC, "boot1.pc");
      idle();
      chk_ifid(1, 32'h0, 32'h0, 1'b0, "wrap");
      chk(1, SIG_PC, 32'h0, "wrap.pc");
      chk(1, SIG_BC, 32'd2, "wrap.bc");
      idle();
      chk_ifid(1, 32'hC000_0000, 32'd4, 1'b1, "wrap.w0");
      chk(1, SIG_FC, 32'd1, "wrap.fc");
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk(1, SIG_BC, 32'd3, "st1.bc");
      chk(1, SIG_PC, 32'd4, "st1.pc");
      rst1 = 1'b1;
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_reset(1, 32'hFFFF_FFFC, "rst1b");

      @(negedge clk);
      #1;
      if (q_sig.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q_sig.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
